// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares the single port of a per-core byte-enabled BRAM between NUM_REQ
// requesters (for example the core load/store unit and the program loader).
// Requesters are served round-robin. A requester can hold the port across
// several transfers (atomic read-modify-write) by raising req_lock. Read
// data returns to the issuing requester READ_LATENCY cycles after issue.
//
// Handshake: requester i presents a request by raising req_valid[i] with its
// we/be/addr/wdata/lock slice. The arbiter raises req_ready[i] in the same
// cycle, combinationally, when the port is granted to i. A transfer happens
// on the rising edge where req_valid[i] and req_ready[i] are both 1. That is
// the only cycle in which the request fields are sampled, so a requester may
// change or drop its request freely while it is not ready. At most one
// req_ready bit is high per cycle.
//
// Ports:
//   clk        clock, all state on the rising edge
//   reset      asynchronous, active-high reset
//   req_valid  [NUM_REQ]             request present per requester
//   req_ready  [NUM_REQ]             grant / accept, one-hot or zero
//   req_lock   [NUM_REQ]             keep the grant after this transfer
//   req_we     [NUM_REQ]             1 = write, 0 = read
//   req_be     [NUM_REQ*NB_COL]      byte enables, slice i*NB_COL +: NB_COL
//   req_addr   [NUM_REQ*ADDR_WIDTH]  word addresses, sliced the same way
//   req_wdata  [NUM_REQ*DWIDTH]      write data, sliced the same way
//   rsp_valid  [NUM_REQ]             read data valid for requester i
//   rsp_rdata  [DWIDTH]              read data shared by all requesters
//   mem_en     BRAM port enable
//   mem_we     [NB_COL]              BRAM byte write enables
//   mem_addr   [ADDR_WIDTH]          BRAM word address
//   mem_wdata  [DWIDTH]              BRAM write data
//   mem_rdata  [DWIDTH]              BRAM read data, READ_LATENCY after mem_en
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_WIDTH   = 10,
    parameter int DWIDTH       = 32,
    parameter int NB_COL       = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_lock,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*NB_COL-1:0]      req_be,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DWIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DWIDTH-1:0]              rsp_rdata,
    output logic                           mem_en,
    output logic [NB_COL-1:0]              mem_we,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DWIDTH-1:0]              mem_wdata,
    input  logic [DWIDTH-1:0]              mem_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // -----------------------------------------------------------------------
    // Per-requester views of the flattened request buses
    // -----------------------------------------------------------------------
    logic [NB_COL-1:0]     be_arr    [NUM_REQ];
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DWIDTH-1:0]     wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign be_arr[g]    = req_be[g*NB_COL +: NB_COL];
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DWIDTH +: DWIDTH];
    end

    // -----------------------------------------------------------------------
    // Arbitration state
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] rr_ptr;      // first requester to consider this cycle
    logic             lock_valid;  // a requester currently owns the port
    logic [IDX_W-1:0] lock_idx;    // which requester owns it

    // Read tag pipeline: one stage per cycle of BRAM read latency. The last
    // stage lines up with mem_rdata for the read it describes.
    logic             tag_v   [READ_LATENCY];
    logic [IDX_W-1:0] tag_idx [READ_LATENCY];

    // -----------------------------------------------------------------------
    // Grant selection (combinational)
    // -----------------------------------------------------------------------
    logic             grant;       // a transfer happens this cycle
    logic [IDX_W-1:0] winner;      // requester being served
    logic [IDX_W:0]   cand_sum;    // one extra bit so the wrap test cannot overflow
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] next_rr;

    always_comb begin
        grant    = 1'b0;
        winner   = '0;
        cand_sum = '0;
        cand     = '0;
        // Search from rr_ptr upward, wrapping modulo NUM_REQ. The first
        // valid candidate wins; later ones are ignored.
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!grant && req_valid[cand]) begin
                grant  = 1'b1;
                winner = cand;
            end
        end
        // A held lock overrides the search: only the owner may be served,
        // and everyone else waits even when the owner has nothing to do.
        if (lock_valid) begin
            grant  = req_valid[lock_idx];
            winner = lock_idx;
        end
        // Nothing is accepted while reset is held.
        if (reset) begin
            grant = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant && (winner == IDX_W'(i));
        end
    end

    // Pointer value used after an unlocked transfer: the slot just past the
    // winner, wrapping at NUM_REQ (which need not be a power of two).
    always_comb begin
        if (winner == IDX_W'(NUM_REQ - 1)) begin
            next_rr = '0;
        end else begin
            next_rr = winner + IDX_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // BRAM port drive
    // -----------------------------------------------------------------------
    always_comb begin
        mem_en    = grant;
        mem_addr  = addr_arr[winner];
        mem_wdata = wdata_arr[winner];
        mem_we    = '0;
        if (grant && req_we[winner]) begin
            mem_we = be_arr[winner];
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin pointer and lock ownership
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_idx   <= '0;
        end else if (grant) begin
            if (req_lock[winner]) begin
                // Take or keep ownership. The pointer stays put so that,
                // once released, arbitration resumes past the owner.
                lock_valid <= 1'b1;
                lock_idx   <= winner;
            end else begin
                // Unlocked transfer: this also ends any lock the winner held.
                lock_valid <= 1'b0;
                rr_ptr     <= next_rr;
            end
        end
        // No transfer: state holds. An idle owner keeps its lock.
    end

    // -----------------------------------------------------------------------
    // Read tag pipeline
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                tag_v[s]   <= 1'b0;
                tag_idx[s] <= '0;
            end
        end else begin
            // Writes and idle cycles push an invalid tag so that the stage
            // count always matches the BRAM's fixed output latency.
            tag_v[0]   <= grant && !req_we[winner];
            tag_idx[0] <= winner;
            for (int s = 1; s < READ_LATENCY; s++) begin
                tag_v[s]   <= tag_v[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Response routing
    // -----------------------------------------------------------------------
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = tag_v[READ_LATENCY-1] &&
                           (tag_idx[READ_LATENCY-1] == IDX_W'(i));
        end
    end

    // Read data is passed straight through from the BRAM; rsp_valid says
    // who it belongs to. Responses leave in issue order by construction.
    assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Two arbiter instances share the same request stimulus: dut1 with a
// 1-cycle BRAM and dut2 with a 2-cycle BRAM. Each has a behavioural
// write-first, byte-enabled BRAM model. On reset the model memory holds
// 0xC0DE0000 | address in every word, except word 0x005 which holds
// 0x11223344. Inputs are driven at the falling edge and outputs are
// checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared request stimulus ----------------
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_lock;
  logic [NR-1:0]    req_we;
  logic [NR*NB-1:0] req_be;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;

  // ---------------- dut1 (READ_LATENCY = 1) ----------------
  logic [NR-1:0] ready1, rsp_valid1;
  logic [DW-1:0] rsp_rdata1, mem_wdata1, mem_rdata1;
  logic          mem_en1;
  logic [NB-1:0] mem_we1;
  logic [AW-1:0] mem_addr1;

  bram_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DWIDTH(DW), .NB_COL(NB),
                      .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(ready1), .req_lock(req_lock),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  // ---------------- dut2 (READ_LATENCY = 2) ----------------
  logic [NR-1:0] ready2, rsp_valid2;
  logic [DW-1:0] rsp_rdata2, mem_wdata2, mem_rdata2;
  logic          mem_en2;
  logic [NB-1:0] mem_we2;
  logic [AW-1:0] mem_addr2;

  bram_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DWIDTH(DW), .NB_COL(NB),
                      .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(ready2), .req_lock(req_lock),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  // ---------------- BRAM models (write-first per column) ----------------
  logic [DW-1:0] mem1 [1024];
  logic [DW-1:0] word1, rd1_q;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem1[i] <= 32'hC0DE0000 | 32'(i);
      mem1[5] <= 32'h11223344;
    end else if (mem_en1) begin
      word1 = mem1[mem_addr1];
      for (int c = 0; c < NB; c++) if (mem_we1[c]) word1[c*8 +: 8] = mem_wdata1[c*8 +: 8];
      mem1[mem_addr1] <= word1;
      rd1_q <= word1;
    end
  end
  assign mem_rdata1 = rd1_q;

  logic [DW-1:0] mem2 [1024];
  logic [DW-1:0] word2, rd2_a, rd2_b;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem2[i] <= 32'hC0DE0000 | 32'(i);
      mem2[5] <= 32'h11223344;
    end else if (mem_en2) begin
      word2 = mem2[mem_addr2];
      for (int c = 0; c < NB; c++) if (mem_we2[c]) word2[c*8 +: 8] = mem_wdata2[c*8 +: 8];
      mem2[mem_addr2] <= word2;
      rd2_a <= word2;
    end
    rd2_b <= rd2_a;
  end
  assign mem_rdata2 = rd2_b;

  // ---------------- counters ----------------
  int vectors = 0;
  int miscompares = 0;

  // ---------------- driver tasks ----------------
  task automatic drive(input int i, input logic v, input logic we, input logic lk,
                       input logic [NB-1:0] be, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd);
    req_valid[i]          = v;
    req_we[i]             = we;
    req_lock[i]           = lk;
    req_be[i*NB +: NB]    = be;
    req_addr[i*AW +: AW]  = addr;
    req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic idle_all();
    req_valid = '0;
    req_lock  = '0;
    req_we    = '0;
    req_be    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 10'h010, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 4'h0, 10'h020, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    vectors++; if (ready1 !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b want %b", ready1, 2'b00); end
    vectors++; if (mem_en1 !== 1'b0) begin miscompares++; $display("FAIL reset_mem_en: got %b want 0", mem_en1); end
    vectors++; if (rsp_valid1 !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid1); end
    vectors++; if (ready2 !== 2'b00) begin miscompares++; $display("FAIL reset_ready_lat2: got %b want 00", ready2); end
    rst = 1'b0; #1;
    vectors++; if (ready1 !== 2'b01) begin miscompares++; $display("FAIL reset_first_grant: got %b want 01", ready1); end
    vectors++; if (mem_addr1 !== 10'h010) begin miscompares++; $display("FAIL reset_first_addr: got %h want 010", mem_addr1); end
    idle_all();
  endtask

  task automatic test_write_read();
    @(negedge clk);
    idle_all();
    drive(0, 1'b1, 1'b1, 1'b0, 4'b0011, 10'h005, 32'hAABBCCDD); #1;
    vectors++; if (ready1 !== 2'b01) begin miscompares++; $display("FAIL wr_ready: got %b want 01", ready1); end
    vectors++; if (mem_we1 !== 4'b0011) begin miscompares++; $display("FAIL wr_mem_we: got %b want 0011", mem_we1); end
    vectors++; if (mem_wdata1 !== 32'hAABBCCDD) begin miscompares++; $display("FAIL wr_mem_wdata: got %h want aabbccdd", mem_wdata1); end
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 4'b1111, 10'h005, 32'h0); #1;
    vectors++; if (ready1 !== 2'b01) begin miscompares++; $display("FAIL rd_ready: got %b want 01", ready1); end
    vectors++; if (mem_we1 !== 4'b0000) begin miscompares++; $display("FAIL rd_mem_we: got %b want 0000", mem_we1); end
    vectors++; if (rsp_valid1 !== 2'b00) begin miscompares++; $display("FAIL wr_no_rsp: got %b want 00", rsp_valid1); end
    @(negedge clk);
    idle_all();
    drive(1, 1'b1, 1'b0, 1'b0, 4'h0, 10'h007, 32'h0); #1;
    vectors++; if (rsp_valid1 !== 2'b01) begin miscompares++; $display("FAIL raw_rsp_valid: got %b want 01", rsp_valid1); end
    vectors++; if (rsp_rdata1 !== 32'h1122CCDD) begin miscompares++; $display("FAIL raw_rsp_data: got %h want 1122ccdd", rsp_rdata1); end
    vectors++; if (ready1 !== 2'b10) begin miscompares++; $display("FAIL single_req1_grant: got %b want 10", ready1); end
    @(negedge clk);
    idle_all(); #1;
    vectors++; if (rsp_valid1 !== 2'b10) begin miscompares++; $display("FAIL req1_rsp_valid: got %b want 10", rsp_valid1); end
    vectors++; if (rsp_rdata1 !== 32'hC0DE0007) begin miscompares++; $display("FAIL req1_rsp_data: got %h want c0de0007", rsp_rdata1); end
  endtask

  task automatic test_fairness();
    logic [NR-1:0] exp_ready, prev_ready;
    logic [DW-1:0] prev_data;
    prev_ready = 2'b00;
    prev_data  = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 10'(16 + k), 32'h0);
      drive(1, 1'b1, 1'b0, 1'b0, 4'h0, 10'(32 + k), 32'h0); #1;
      exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
      vectors++; if (ready1 !== exp_ready) begin miscompares++; $display("FAIL fair_grant[%0d]: got %b want %b", k, ready1, exp_ready); end
      vectors++; if (rsp_valid1 !== prev_ready) begin miscompares++; $display("FAIL fair_rsp_valid[%0d]: got %b want %b", k, rsp_valid1, prev_ready); end
      if (k > 0) begin
        vectors++; if (rsp_rdata1 !== prev_data) begin miscompares++; $display("FAIL fair_rsp_data[%0d]: got %h want %h", k, rsp_rdata1, prev_data); end
      end
      prev_ready = exp_ready;
      prev_data  = 32'hC0DE0000 | ((k % 2 == 0) ? 32'(16 + k) : 32'(32 + k));
    end
    @(negedge clk);
    idle_all(); #1;
    vectors++; if (rsp_valid1 !== prev_ready) begin miscompares++; $display("FAIL fair_last_rsp_valid: got %b want %b", rsp_valid1, prev_ready); end
    vectors++; if (rsp_rdata1 !== prev_data) begin miscompares++; $display("FAIL fair_last_rsp_data: got %h want %h", rsp_rdata1, prev_data); end
  endtask

  task automatic test_lock();
    // Move the pointer to requester 1 with a single unlocked read by 0.
    @(negedge clk);
    idle_all();
    drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 10'h030, 32'h0); #1;
    vectors++; if (ready1 !== 2'b01) begin miscompares++; $display("FAIL lock_setup_grant: got %b want 01", ready1); end
    // Locked read by 1 while 0 keeps asking.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 10'h031, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b1, 4'h0, 10'h3FF, 32'h0); #1;
    vectors++; if (ready1 !== 2'b10) begin miscompares++; $display("FAIL lock_owner_grant: got %b want 10", ready1); end
    vectors++; if (rsp_rdata1 !== 32'hC0DE0030 || rsp_valid1 !== 2'b01) begin miscompares++; $display("FAIL lock_setup_rsp: got %b/%h want 01/c0de0030", rsp_valid1, rsp_rdata1); end
    // Owner idle: requester 0 must still wait.
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0); #1;
    vectors++; if (ready1 !== 2'b00) begin miscompares++; $display("FAIL lock_idle_stall: got %b want 00", ready1); end
    vectors++; if (mem_en1 !== 1'b0) begin miscompares++; $display("FAIL lock_idle_mem_en: got %b want 0", mem_en1); end
    vectors++; if (rsp_valid1 !== 2'b10 || rsp_rdata1 !== 32'hC0DE03FF) begin miscompares++; $display("FAIL lock_read_rsp: got %b/%h want 10/c0de03ff", rsp_valid1, rsp_rdata1); end
    // Unlocked write by the owner ends the lock.
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b0, 4'b1111, 10'h3FF, 32'hDEADBEEF); #1;
    vectors++; if (ready1 !== 2'b10) begin miscompares++; $display("FAIL lock_unlock_write: got %b want 10", ready1); end
    vectors++; if (mem_we1 !== 4'b1111) begin miscompares++; $display("FAIL lock_write_we: got %b want 1111", mem_we1); end
    // Pointer advanced past the owner: requester 0 wins next.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 10'h3FF, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 4'h0, 10'h3FE, 32'h0); #1;
    vectors++; if (ready1 !== 2'b01) begin miscompares++; $display("FAIL lock_release_grant: got %b want 01", ready1); end
    vectors++; if (rsp_valid1 !== 2'b00) begin miscompares++; $display("FAIL lock_write_no_rsp: got %b want 00", rsp_valid1); end
    @(negedge clk);
    idle_all(); #1;
    vectors++; if (rsp_valid1 !== 2'b01 || rsp_rdata1 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lock_raw_rsp: got %b/%h want 01/deadbeef", rsp_valid1, rsp_rdata1); end
  endtask

  task automatic test_latency2();
    // Pointer is at 1 here; a lone requester 0 still wins.
    @(negedge clk);
    idle_all();
    drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 10'h001, 32'h0); #1;
    vectors++; if (ready2 !== 2'b01) begin miscompares++; $display("FAIL lat2_grant0: got %b want 01", ready2); end
    @(negedge clk);
    idle_all();
    drive(1, 1'b1, 1'b0, 1'b0, 4'h0, 10'h002, 32'h0); #1;
    vectors++; if (ready2 !== 2'b10) begin miscompares++; $display("FAIL lat2_grant1: got %b want 10", ready2); end
    vectors++; if (rsp_valid2 !== 2'b00) begin miscompares++; $display("FAIL lat2_early_rsp: got %b want 00", rsp_valid2); end
    vectors++; if (rsp_valid1 !== 2'b01 || rsp_rdata1 !== 32'hC0DE0001) begin miscompares++; $display("FAIL lat1_rsp: got %b/%h want 01/c0de0001", rsp_valid1, rsp_rdata1); end
    @(negedge clk);
    idle_all(); #1;
    vectors++; if (rsp_valid2 !== 2'b01) begin miscompares++; $display("FAIL lat2_rsp0_valid: got %b want 01", rsp_valid2); end
    vectors++; if (rsp_rdata2 !== 32'hC0DE0001) begin miscompares++; $display("FAIL lat2_rsp0_data: got %h want c0de0001", rsp_rdata2); end
    @(negedge clk); #1;
    vectors++; if (rsp_valid2 !== 2'b10) begin miscompares++; $display("FAIL lat2_rsp1_valid: got %b want 10", rsp_valid2); end
    vectors++; if (rsp_rdata2 !== 32'hC0DE0002) begin miscompares++; $display("FAIL lat2_rsp1_data: got %h want c0de0002", rsp_rdata2); end
    @(negedge clk); #1;
    vectors++; if (rsp_valid2 !== 2'b00) begin miscompares++; $display("FAIL lat2_drained: got %b want 00", rsp_valid2); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle_all();
    drive(1, 1'b1, 1'b0, 1'b1, 4'h0, 10'h005, 32'h0); #1;
    vectors++; if (ready1 !== 2'b10) begin miscompares++; $display("FAIL rm_lock_grant: got %b want 10", ready1); end
    @(negedge clk);
    idle_all();
    rst = 1'b1; #1;
    vectors++; if (rsp_valid1 !== 2'b00) begin miscompares++; $display("FAIL rm_rsp_dropped: got %b want 00", rsp_valid1); end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 10'h040, 32'h0); #1;
    vectors++; if (ready1 !== 2'b01) begin miscompares++; $display("FAIL rm_lock_cleared: got %b want 01", ready1); end
    vectors++; if (rsp_valid2 !== 2'b00) begin miscompares++; $display("FAIL rm_rsp_dropped_lat2: got %b want 00", rsp_valid2); end
    @(negedge clk);
    idle_all(); #1;
    vectors++; if (rsp_valid1 !== 2'b01 || rsp_rdata1 !== 32'hC0DE0040) begin miscompares++; $display("FAIL rm_after_rsp: got %b/%h want 01/c0de0040", rsp_valid1, rsp_rdata1); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_write_read();
    test_fairness();
    test_lock();
    test_latency2();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
